// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon finalization datapath: FSM states,
// rate-variant encodings, round-count constant and tag-mask helper.
package ascon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } fin_state_t;

    localparam int RATE_ASCON128  = 1;
    localparam int RATE_ASCON128A = 2;

    localparam logic [3:0] ASCON_P12 = 4'd12;

    // Ones in the upper tag_bits positions of a 128-bit word, zeros below.
    function automatic logic [127:0] tag_mask(input int tag_bits);
        logic [127:0] ones;
        ones = '1;
        return ones << (128 - tag_bits);
    endfunction

endpackage

// File: rtl/ascon_tag_cmp.sv
// Masked tag comparator: XOR then full-width OR-reduce, so the result never
// depends on where (or whether) the first differing bit occurs.
module ascon_tag_cmp
    import ascon_pkg::*;
#(
    parameter int TAG_BITS = 128
) (
    input  logic [127:0] full,
    input  logic [127:0] expected,
    output logic         match
);

    localparam logic [127:0] MASK = tag_mask(TAG_BITS);

    assign match = ~|((full ^ expected) & MASK);

endmodule

// File: rtl/ascon_final_tag_unit.sv
// Ascon AEAD finalization: key injection, p12 request, tag formation and
// constant-time tag verification.
module ascon_final_tag_unit
    import ascon_pkg::*;
#(
    parameter int RATE_WORDS = 2,
    parameter int TAG_BITS   = 128,
    parameter int P_ROUNDS   = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_valid_i,
    output logic          start_ready_o,
    input  logic          decrypt_i,
    input  logic          abort_i,
    input  logic [127:0]  key_i,
    input  logic [63:0]   x0_i,
    input  logic [63:0]   x1_i,
    input  logic [63:0]   x2_i,
    input  logic [63:0]   x3_i,
    input  logic [63:0]   x4_i,
    input  logic [127:0]  tag_exp_i,
    output logic          perm_valid_o,
    input  logic          perm_ready_i,
    output logic [3:0]    perm_rounds_o,
    output logic [63:0]   px0_o,
    output logic [63:0]   px1_o,
    output logic [63:0]   px2_o,
    output logic [63:0]   px3_o,
    output logic [63:0]   px4_o,
    input  logic          perm_done_i,
    input  logic [63:0]   px3_i,
    input  logic [63:0]   px4_i,
    output logic          tag_valid_o,
    input  logic          tag_ready_i,
    output logic [127:0]  tag_o,
    output logic          tag_ok_o,
    output logic          busy_o
);

    localparam logic [127:0] MASK   = tag_mask(TAG_BITS);
    localparam logic [3:0]   ROUNDS = 4'(P_ROUNDS);

    fin_state_t    state;
    fin_state_t    state_next;
    logic          accept;
    logic          capture;

    logic [63:0]   st0, st1, st2, st3, st4;
    logic [127:0]  key;
    logic [127:0]  tag_exp;
    logic          verify;

    logic [127:0]  full;
    logic          match;

    assign perm_rounds_o = ROUNDS;
    assign start_ready_o = (state == ST_IDLE);
    assign busy_o        = (state != ST_IDLE);

    // The permutation sees the latched state with the key folded into the
    // two words that follow the rate portion.
    always_comb begin
        px0_o = st0;
        px1_o = st1;
        px2_o = st2;
        px3_o = st3;
        px4_o = st4;
        if (RATE_WORDS == RATE_ASCON128) begin
            px1_o = st1 ^ key[127:64];
            px2_o = st2 ^ key[63:0];
        end else begin
            px2_o = st2 ^ key[127:64];
            px3_o = st3 ^ key[63:0];
        end
    end

    assign full = {px3_i ^ key[127:64], px4_i ^ key[63:0]};

    ascon_tag_cmp #(
        .TAG_BITS (TAG_BITS)
    ) u_cmp (
        .full     (full),
        .expected (tag_exp),
        .match    (match)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_valid_i) begin
                    accept     = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (perm_ready_i) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (perm_done_i) begin
                    capture    = 1'b1;
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (tag_ready_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Abort overrides every handshake that happens in the same cycle.
        if (abort_i) begin
            state_next = ST_IDLE;
            accept     = 1'b0;
            capture    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            perm_valid_o <= 1'b0;
            tag_valid_o  <= 1'b0;
            tag_o        <= '0;
            tag_ok_o     <= 1'b0;
            st0          <= '0;
            st1          <= '0;
            st2          <= '0;
            st3          <= '0;
            st4          <= '0;
            key          <= '0;
            tag_exp      <= '0;
            verify       <= 1'b0;
        end else begin
            state        <= state_next;
            perm_valid_o <= (state_next == ST_REQ);
            tag_valid_o  <= (state_next == ST_OUT);
            if (accept) begin
                st0     <= x0_i;
                st1     <= x1_i;
                st2     <= x2_i;
                st3     <= x3_i;
                st4     <= x4_i;
                key     <= key_i;
                tag_exp <= tag_exp_i;
                verify  <= decrypt_i;
            end
            // In verify mode the computed tag never leaves the unit.
            if (capture) begin
                tag_o    <= verify ? '0 : (full & MASK);
                tag_ok_o <= verify & match;
            end else if (state_next == ST_IDLE) begin
                tag_o    <= '0;
                tag_ok_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ascon_final_tag_unit.sv
// Self-checking bench: two instances (Ascon-128a/128-bit tag and
// Ascon-128/64-bit tag) driven in lockstep and compared against a reference model.
module tb_ascon_final_tag_unit;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_valid = 1'b0;
    logic          decrypt = 1'b0;
    logic          abort = 1'b0;
    logic [127:0]  key = '0;
    logic [63:0]   x [5];
    logic [127:0]  tag_exp = '0;
    logic          perm_ready = 1'b0;
    logic          perm_done = 1'b0;
    logic [63:0]   px3_in = '0;
    logic [63:0]   px4_in = '0;
    logic          tag_ready = 1'b0;

    logic          a_start_ready, a_perm_valid, a_tag_valid, a_tag_ok, a_busy;
    logic [3:0]    a_rounds;
    logic [63:0]   a_px [5];
    logic [127:0]  a_tag;
    logic          b_start_ready, b_perm_valid, b_tag_valid, b_tag_ok, b_busy;
    logic [3:0]    b_rounds;
    logic [63:0]   b_px [5];
    logic [127:0]  b_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ascon_final_tag_unit #(.RATE_WORDS(2), .TAG_BITS(128), .P_ROUNDS(12)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_valid_i(start_valid), .start_ready_o(a_start_ready),
        .decrypt_i(decrypt), .abort_i(abort), .key_i(key),
        .x0_i(x[0]), .x1_i(x[1]), .x2_i(x[2]), .x3_i(x[3]), .x4_i(x[4]),
        .tag_exp_i(tag_exp), .perm_valid_o(a_perm_valid), .perm_ready_i(perm_ready),
        .perm_rounds_o(a_rounds),
        .px0_o(a_px[0]), .px1_o(a_px[1]), .px2_o(a_px[2]), .px3_o(a_px[3]), .px4_o(a_px[4]),
        .perm_done_i(perm_done), .px3_i(px3_in), .px4_i(px4_in),
        .tag_valid_o(a_tag_valid), .tag_ready_i(tag_ready), .tag_o(a_tag),
        .tag_ok_o(a_tag_ok), .busy_o(a_busy)
    );

    ascon_final_tag_unit #(.RATE_WORDS(1), .TAG_BITS(64), .P_ROUNDS(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_valid_i(start_valid), .start_ready_o(b_start_ready),
        .decrypt_i(decrypt), .abort_i(abort), .key_i(key),
        .x0_i(x[0]), .x1_i(x[1]), .x2_i(x[2]), .x3_i(x[3]), .x4_i(x[4]),
        .tag_exp_i(tag_exp), .perm_valid_o(b_perm_valid), .perm_ready_i(perm_ready),
        .perm_rounds_o(b_rounds),
        .px0_o(b_px[0]), .px1_o(b_px[1]), .px2_o(b_px[2]), .px3_o(b_px[3]), .px4_o(b_px[4]),
        .perm_done_i(perm_done), .px3_i(px3_in), .px4_i(px4_in),
        .tag_valid_o(b_tag_valid), .tag_ready_i(tag_ready), .tag_o(b_tag),
        .tag_ok_o(b_tag_ok), .busy_o(b_busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] exp_px(int rate, int idx, logic [63:0] v, logic [127:0] k);
        if ((rate == 1 && idx == 1) || (rate == 2 && idx == 2)) return v ^ k[127:64];
        if ((rate == 1 && idx == 2) || (rate == 2 && idx == 3)) return v ^ k[63:0];
        return v;
    endfunction

    function automatic logic [127:0] exp_full(logic [63:0] p3, logic [63:0] p4, logic [127:0] k);
        return {p3 ^ k[127:64], p4 ^ k[63:0]};
    endfunction

    function automatic logic [127:0] keep_mask(int bits);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < bits; i++) m[127-i] = 1'b1;
        return m;
    endfunction

    function automatic logic [127:0] exp_tag(int bits, logic dec, logic [127:0] f);
        if (dec) return '0;
        return f & keep_mask(bits);
    endfunction

    function automatic logic exp_ok(int bits, logic dec, logic [127:0] f, logic [127:0] te);
        if (!dec) return 1'b0;
        for (int i = 0; i < bits; i++) if (f[127-i] !== te[127-i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    // ---------------- drivers (no checking) ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive_start();
        start_valid = 1'b1; step(); start_valid = 1'b0;
    endtask

    task automatic drive_perm_accept();
        perm_ready = 1'b1; step(); perm_ready = 1'b0;
    endtask

    task automatic drive_done(input logic [63:0] p3, input logic [63:0] p4);
        px3_in = p3; px4_in = p4; perm_done = 1'b1; step(); perm_done = 1'b0;
    endtask

    task automatic drive_tag_accept();
        tag_ready = 1'b1; step(); tag_ready = 1'b0;
    endtask

    task automatic load_random(input logic dec);
        decrypt = dec;
        key = {r64(), r64()};
        for (int i = 0; i < 5; i++) x[i] = r64();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        checks++;
        if (a_start_ready !== 1'b1 || a_busy !== 1'b0 || b_start_ready !== 1'b1 || b_busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl got a_rdy=%b a_busy=%b b_rdy=%b b_busy=%b want 1 0 1 0",
                               a_start_ready, a_busy, b_start_ready, b_busy);
        end
        checks++;
        if (a_perm_valid !== 1'b0 || a_tag_valid !== 1'b0 || b_perm_valid !== 1'b0 || b_tag_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valids got %b%b%b%b want 0000",
                               a_perm_valid, a_tag_valid, b_perm_valid, b_tag_valid);
        end
        checks++;
        if (a_tag !== '0 || b_tag !== '0 || a_tag_ok !== 1'b0 || b_tag_ok !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_tag got a=%h b=%h ok=%b%b want zero", a_tag, b_tag, a_tag_ok, b_tag_ok);
        end
        checks++;
        if (a_rounds !== 4'd12 || b_rounds !== 4'd12) begin
            errors++; $display("[TB] FAIL rounds got %0d %0d want 12", a_rounds, b_rounds);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_spec_vectors();
        logic [63:0]  p3, p4;
        logic [127:0] f;
        logic [127:0] want_a, want_b;
        decrypt = 1'b0;
        key = {64'h0001020304050607, 64'h08090A0B0C0D0E0F};
        x[0] = r64(); x[1] = r64(); x[2] = '0; x[3] = '0; x[4] = r64();
        // Vector 1: stub echoes the permutation inputs x3/x4.
        drive_start();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (a_px[i] !== exp_px(2, i, x[i], key) || b_px[i] !== exp_px(1, i, x[i], key)) begin
                errors++; $display("[TB] FAIL inject_px%0d got a=%h b=%h want a=%h b=%h", i, a_px[i], b_px[i],
                                   exp_px(2, i, x[i], key), exp_px(1, i, x[i], key));
            end
        end
        checks++;
        if (a_perm_valid !== 1'b1 || a_start_ready !== 1'b0 || a_busy !== 1'b1) begin
            errors++; $display("[TB] FAIL start_latency got pv=%b rdy=%b busy=%b want 1 0 1",
                               a_perm_valid, a_start_ready, a_busy);
        end
        drive_perm_accept();
        checks++;
        if (a_perm_valid !== 1'b0 || b_perm_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL perm_valid_drop got %b %b want 0 0", a_perm_valid, b_perm_valid);
        end
        p3 = exp_px(2, 3, x[3], key);
        p4 = exp_px(2, 4, x[4], key);
        f = exp_full(p3, p4, key);
        drive_done(p3, p4);
        checks++;
        if (a_tag_valid !== 1'b1 || a_tag !== exp_tag(128, 1'b0, f) || b_tag !== exp_tag(64, 1'b0, f) || a_tag_ok !== 1'b0) begin
            errors++; $display("[TB] FAIL echo_tag got v=%b a=%h b=%h ok=%b want v=1 a=%h b=%h ok=0",
                               a_tag_valid, a_tag, b_tag, a_tag_ok, exp_tag(128, 1'b0, f), exp_tag(64, 1'b0, f));
        end
        drive_tag_accept();
        // Vector 2: all-ones x3 result and zero x4 result.
        drive_start();
        drive_perm_accept();
        drive_done('1, '0);
        want_a = {64'hFFFEFDFCFBFAF9F8, 64'h08090A0B0C0D0E0F};
        want_b = {64'hFFFEFDFCFBFAF9F8, 64'h0};
        checks++;
        if (a_tag !== want_a || b_tag !== want_b) begin
            errors++; $display("[TB] FAIL ones_tag got a=%h b=%h want a=%h b=%h", a_tag, b_tag, want_a, want_b);
        end
        drive_tag_accept();
        checks++;
        if (a_start_ready !== 1'b1 || a_tag_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL after_out got rdy=%b tv=%b want 1 0", a_start_ready, a_tag_valid);
        end
    endtask

    task automatic test_decrypt_mask();
        logic [63:0]  p3, p4;
        logic [127:0] f;
        logic [127:0] flip;
        for (int c = 0; c < 3; c++) begin
            load_random(1'b1);
            p3 = r64(); p4 = r64();
            f = exp_full(p3, p4, key);
            flip = '0;
            if (c == 0) flip[0] = 1'b1;
            if (c == 1) flip[127] = 1'b1;
            tag_exp = f ^ flip;
            drive_start();
            drive_perm_accept();
            drive_done(p3, p4);
            checks++;
            if (a_tag_ok !== exp_ok(128, 1'b1, f, tag_exp) || b_tag_ok !== exp_ok(64, 1'b1, f, tag_exp)) begin
                errors++; $display("[TB] FAIL dec_ok case%0d got a=%b b=%b want a=%b b=%b", c, a_tag_ok, b_tag_ok,
                                   exp_ok(128, 1'b1, f, tag_exp), exp_ok(64, 1'b1, f, tag_exp));
            end
            checks++;
            if (a_tag !== '0 || b_tag !== '0) begin
                errors++; $display("[TB] FAIL dec_leak case%0d got a=%h b=%h want 0", c, a_tag, b_tag);
            end
            drive_tag_accept();
        end
    endtask

    task automatic test_handshake();
        logic [63:0]  p3, p4;
        logic [127:0] f;
        load_random(1'b0);
        p3 = r64(); p4 = r64();
        f = exp_full(p3, p4, key);
        drive_start();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (a_perm_valid !== 1'b1 || a_px[2] !== exp_px(2, 2, x[2], key) || b_px[1] !== exp_px(1, 1, x[1], key)
                || a_start_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL req_hold cyc%0d got pv=%b px2=%h rdy=%b", i, a_perm_valid, a_px[2], a_start_ready);
            end
            step();
        end
        drive_perm_accept();
        step();
        checks++;
        if (a_perm_valid !== 1'b0 || a_tag_valid !== 1'b0 || a_busy !== 1'b1) begin
            errors++; $display("[TB] FAIL wait_state got pv=%b tv=%b busy=%b want 0 0 1", a_perm_valid, a_tag_valid, a_busy);
        end
        drive_done(p3, p4);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_tag_valid !== 1'b1 || a_tag !== exp_tag(128, 1'b0, f) || b_tag !== exp_tag(64, 1'b0, f)
                || a_start_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL out_hold cyc%0d got tv=%b a=%h b=%h rdy=%b", i, a_tag_valid, a_tag, b_tag, a_start_ready);
            end
            step();
        end
        drive_tag_accept();
        checks++;
        if (a_start_ready !== 1'b1 || b_start_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL ready_return got %b %b want 1 1", a_start_ready, b_start_ready);
        end
    endtask

    task automatic test_abort();
        logic [63:0]  p3, p4;
        logic [127:0] f;
        load_random(1'b0);
        p3 = r64(); p4 = r64();
        drive_start();
        drive_perm_accept();
        abort = 1'b1; px3_in = p3; px4_in = p4; perm_done = 1'b1;
        step();
        abort = 1'b0; perm_done = 1'b0;
        checks++;
        if (a_busy !== 1'b0 || a_tag_valid !== 1'b0 || a_start_ready !== 1'b1 || a_tag !== '0) begin
            errors++; $display("[TB] FAIL abort_wait got busy=%b tv=%b rdy=%b tag=%h", a_busy, a_tag_valid, a_start_ready, a_tag);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_tag_valid !== 1'b0 || b_tag_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL abort_quiet cyc%0d got %b %b want 0 0", i, a_tag_valid, b_tag_valid);
            end
            step();
        end
        drive_start();
        abort = 1'b1; step(); abort = 1'b0;
        checks++;
        if (a_perm_valid !== 1'b0 || a_busy !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_req got pv=%b busy=%b want 0 0", a_perm_valid, a_busy);
        end
        load_random(1'b1);
        p3 = r64(); p4 = r64();
        f = exp_full(p3, p4, key);
        tag_exp = f;
        drive_start();
        drive_perm_accept();
        drive_done(p3, p4);
        checks++;
        if (a_tag_valid !== 1'b1 || a_tag_ok !== 1'b1 || b_tag_ok !== 1'b1) begin
            errors++; $display("[TB] FAIL post_abort got tv=%b ok=%b%b want 1 11", a_tag_valid, a_tag_ok, b_tag_ok);
        end
        abort = 1'b1; tag_ready = 1'b1; step(); abort = 1'b0; tag_ready = 1'b0;
        checks++;
        if (a_tag_ok !== 1'b0 || a_tag_valid !== 1'b0 || a_busy !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_out got ok=%b tv=%b busy=%b want 0 0 0", a_tag_ok, a_tag_valid, a_busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0]  p3, p4;
        load_random(1'b0);
        p3 = r64(); p4 = r64();
        drive_start();
        drive_perm_accept();
        drive_done(p3, p4);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (a_tag_valid !== 1'b0 || a_tag !== '0 || b_tag !== '0 || a_busy !== 1'b0 || a_perm_valid !== 1'b0
            || a_px[2] !== '0 || b_px[1] !== '0) begin
            errors++; $display("[TB] FAIL async_reset got tv=%b a=%h b=%h busy=%b px2=%h", a_tag_valid, a_tag, b_tag, a_busy, a_px[2]);
        end
        step();
        rst_n = 1'b1;
        step();
        drive_done(r64(), r64());
        step();
        checks++;
        if (a_tag_valid !== 1'b0 || a_busy !== 1'b0 || a_tag !== '0 || b_tag_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL spurious_done got tv=%b busy=%b tag=%h", a_tag_valid, a_busy, a_tag);
        end
    endtask

    task automatic test_random();
        logic [63:0]  p3, p4;
        logic [127:0] f;
        logic [127:0] flip;
        logic         dec;
        for (int n = 0; n < 24; n++) begin
            dec = 1'($urandom_range(0, 1));
            load_random(dec);
            p3 = r64(); p4 = r64();
            f = exp_full(p3, p4, key);
            flip = '0;
            case ($urandom_range(0, 2))
                1: flip[$urandom_range(0, 63)] = 1'b1;
                2: flip[$urandom_range(64, 127)] = 1'b1;
                default: ;
            endcase
            tag_exp = f ^ flip;
            drive_start();
            checks++;
            if (a_px[0] !== x[0] || a_px[2] !== exp_px(2, 2, x[2], key) || a_px[3] !== exp_px(2, 3, x[3], key)
                || b_px[1] !== exp_px(1, 1, x[1], key) || b_px[2] !== exp_px(1, 2, x[2], key) || b_px[3] !== x[3]) begin
                errors++; $display("[TB] FAIL rand_px iter%0d got a2=%h a3=%h b1=%h b2=%h", n, a_px[2], a_px[3], b_px[1], b_px[2]);
            end
            repeat ($urandom_range(0, 3)) step();
            drive_perm_accept();
            repeat ($urandom_range(0, 3)) step();
            drive_done(p3, p4);
            checks++;
            if (a_tag !== exp_tag(128, dec, f) || b_tag !== exp_tag(64, dec, f)
                || a_tag_ok !== exp_ok(128, dec, f, tag_exp) || b_tag_ok !== exp_ok(64, dec, f, tag_exp)) begin
                errors++; $display("[TB] FAIL rand_tag iter%0d got a=%h b=%h ok=%b%b want a=%h b=%h ok=%b%b", n,
                                   a_tag, b_tag, a_tag_ok, b_tag_ok, exp_tag(128, dec, f), exp_tag(64, dec, f),
                                   exp_ok(128, dec, f, tag_exp), exp_ok(64, dec, f, tag_exp));
            end
            repeat ($urandom_range(0, 2)) step();
            drive_tag_accept();
            checks++;
            if (a_start_ready !== 1'b1 || b_start_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL rand_ready iter%0d got %b %b want 1 1", n, a_start_ready, b_start_ready);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) x[i] = '0;
        test_reset();
        test_spec_vectors();
        test_decrypt_mask();
        test_handshake();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
